// File: rtl/pc_fetch_sequencer.sv
// Next-PC controller for the ProgramCounter: post-reset hold, sequential fetch, stall, redirect and wrap.
// Optional macro PC_REDIRECT_BUFFER_EN: buffer a redirect that arrives while stalled until the stall lifts.
module pc_fetch_sequencer #(
  parameter logic [31:0] MAX_ADDR    = 32'd248,
  parameter logic [31:0] RESET_VEC   = 32'd0,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      PC,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  output logic [31:0]      NewPC,
  output logic             WriteEnable,
  output logic             IFFlush,
  output logic             Wrapped,
  output logic             AlignErr,
  output logic [CNT_W-1:0] RedirectCount,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic        live_redirect;
  logic [31:0] live_target;
  logic        redirect_acc;
  logic [31:0] redir_target;
  logic        do_write;
  logic [31:0] cand;
  logic        wrap_hit;
  logic        align_hit;

`ifdef PC_REDIRECT_BUFFER_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  assign fsm_state = state_q;

  // Handshake: WriteEnable qualifies NewPC in the same cycle; the PC register loads on the next edge.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    live_redirect = Jump | BranchTaken;
    live_target   = Jump ? JumpTarget : BranchTarget;
    redirect_acc  = 1'b0;
    redir_target  = 32'd0;
    do_write      = 1'b0;
`ifdef PC_REDIRECT_BUFFER_EN
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
`endif
    case (state_q)
      S_HOLD: begin
        if (hold_q <= 4'd1) begin
          hold_d  = 4'd0;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      S_RUN: begin
        if (live_redirect) begin
          redirect_acc = 1'b1;
          redir_target = live_target;
          do_write     = 1'b1;
        end else if (Stall) begin
          state_d = S_STALL;
        end else begin
          do_write = 1'b1;
        end
      end
      S_STALL: begin
`ifdef PC_REDIRECT_BUFFER_EN
        if (Stall) begin
          if (live_redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = live_target;
          end
        end else begin
          state_d = S_RUN;
          pend_d  = 1'b0;
          // A live redirect in the release cycle supersedes the buffered one.
          if (live_redirect) begin
            redirect_acc = 1'b1;
            redir_target = live_target;
            do_write     = 1'b1;
          end else if (pend_q) begin
            redirect_acc = 1'b1;
            redir_target = pend_tgt_q;
            do_write     = 1'b1;
          end
        end
`else
        if (live_redirect) begin
          redirect_acc = 1'b1;
          redir_target = live_target;
          do_write     = 1'b1;
          state_d      = S_RUN;
        end else if (!Stall) begin
          state_d = S_RUN;
        end
`endif
      end
      default: state_d = S_HOLD;
    endcase

    cand = redirect_acc ? {redir_target[31:2], 2'b00} : PC + 32'd4;
    align_hit = redirect_acc & (redir_target[1:0] != 2'b00);

    WriteEnable = do_write;
    wrap_hit    = 1'b0;
    if (state_q == S_HOLD) begin
      NewPC = RESET_VEC;
    end else if (do_write && (cand > MAX_ADDR)) begin
      NewPC    = RESET_VEC;
      wrap_hit = 1'b1;
    end else if (do_write) begin
      NewPC = cand;
    end else begin
      NewPC = PC;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_HOLD;
      hold_q        <= HOLD_INIT;
      IFFlush       <= 1'b0;
      Wrapped       <= 1'b0;
      AlignErr      <= 1'b0;
      RedirectCount <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      IFFlush  <= redirect_acc;
      Wrapped  <= wrap_hit;
      AlignErr <= AlignErr | align_hit;
      if (redirect_acc && (RedirectCount != {CNT_W{1'b1}}))
        RedirectCount <= RedirectCount + CNT_W'(1);
    end
  end

`ifdef PC_REDIRECT_BUFFER_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: combinational outputs checked each cycle, registered
// outputs checked one edge later through an expected queue.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] new_pc;
  logic        write_enable;
  logic        if_flush;
  logic        wrapped;
  logic        align_err;
  logic [15:0] redirect_count;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] pc_model;
  logic        exp_align;
  logic [15:0] exp_cnt;
  logic [18:0] exp_q[$];

  pc_fetch_sequencer dut (
    .Clock        (clk),
    .Reset        (rst),
    .PC           (pc_in),
    .Stall        (stall),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .Jump         (jump),
    .JumpTarget   (jump_target),
    .NewPC        (new_pc),
    .WriteEnable  (write_enable),
    .IFFlush      (if_flush),
    .Wrapped      (wrapped),
    .AlignErr     (align_err),
    .RedirectCount(redirect_count),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_we"},    {31'd0, write_enable}, 32'd0);
    check({tag, "_npc"},   new_pc, 32'd0);
    check({tag, "_flush"}, {31'd0, if_flush}, 32'd0);
    check({tag, "_wrap"},  {31'd0, wrapped}, 32'd0);
    check({tag, "_align"}, {31'd0, align_err}, 32'd0);
    check({tag, "_cnt"},   {16'd0, redirect_count}, 32'd0);
    check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
  endtask

  // driver: one decision cycle
  task automatic step(input string tag, input logic st,
                      input logic b_v, input logic [31:0] b_t,
                      input logic j_v, input logic [31:0] j_t,
                      input logic e_we, input logic [31:0] e_npc,
                      input logic e_flush, input logic e_wrap,
                      input logic set_align, input logic inc);
    logic [18:0] got;
    @(negedge clk);
    pc_in         = pc_model;
    stall         = st;
    branch_taken  = b_v;
    branch_target = b_t;
    jump          = j_v;
    jump_target   = j_t;
    #1;
    check({tag, "_we"},  {31'd0, write_enable}, {31'd0, e_we});
    check({tag, "_npc"}, new_pc, e_npc);
    exp_align = exp_align | set_align;
    if (inc) exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back({e_flush, e_wrap, exp_align, exp_cnt});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, "_flush"}, {31'd0, if_flush},  {31'd0, got[18]});
    check({tag, "_wrap"},  {31'd0, wrapped},   {31'd0, got[17]});
    check({tag, "_align"}, {31'd0, align_err}, {31'd0, got[16]});
    check({tag, "_cnt"},   {16'd0, redirect_count}, {16'd0, got[15:0]});
    if (e_we) pc_model = e_npc;
    stall        = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'd0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0;
    pc_model = 32'd0; exp_align = 1'b0; exp_cnt = 16'd0;

    // reset for three cycles, then one hold cycle and sequential fetch
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;
    step("hold",  0, 0, 0, 0, 0, 0, 32'd0,  0, 0, 0, 0);
    step("seq0",  0, 0, 0, 0, 0, 1, 32'd4,  0, 0, 0, 0);
    step("seq4",  0, 0, 0, 0, 0, 1, 32'd8,  0, 0, 0, 0);
    step("seq8",  0, 0, 0, 0, 0, 1, 32'd12, 0, 0, 0, 0);
    step("seq12", 0, 0, 0, 0, 0, 1, 32'd16, 0, 0, 0, 0);

    // jump beats branch; misaligned target sets sticky AlignErr
    step("jmp_pri",   0, 1, 32'd40, 1, 32'd100, 1, 32'd100, 1, 0, 0, 1);
    step("after_jmp", 0, 0, 0, 0, 0, 1, 32'd104, 0, 0, 0, 0);
    step("jmp_mis",   0, 0, 0, 1, 32'd102, 1, 32'd100, 1, 0, 1, 1);
    step("br_to20",   0, 1, 32'd20, 0, 0, 1, 32'd20, 1, 0, 0, 1);

    // three-cycle stall, release cycle, then sequential resumes
    step("stall1",  1, 0, 0, 0, 0, 0, 32'd20, 0, 0, 0, 0);
    step("stall2",  1, 0, 0, 0, 0, 0, 32'd20, 0, 0, 0, 0);
    step("stall3",  1, 0, 0, 0, 0, 0, 32'd20, 0, 0, 0, 0);
    step("release", 0, 0, 0, 0, 0, 0, 32'd20, 0, 0, 0, 0);
    step("resume",  0, 0, 0, 0, 0, 1, 32'd24, 0, 0, 0, 0);

    // redirect while stalled
    step("st_enter", 1, 0, 0, 0, 0, 0, 32'd24, 0, 0, 0, 0);
`ifdef PC_REDIRECT_BUFFER_EN
    step("st_br_buf",  1, 1, 32'd64, 0, 0, 0, 32'd24, 0, 0, 0, 0);
    step("st_br_appl", 0, 0, 0, 0, 0, 1, 32'd64, 1, 0, 0, 1);
    step("after_buf",  0, 0, 0, 0, 0, 1, 32'd68, 0, 0, 0, 0);
    step("st_enter2",  1, 0, 0, 0, 0, 0, 32'd68, 0, 0, 0, 0);
    step("st_jmp_buf", 1, 0, 0, 1, 32'd120, 0, 32'd68, 0, 0, 0, 0);
    step("live_over",  0, 1, 32'd80, 0, 0, 1, 32'd80, 1, 0, 0, 1);
    step("after_live", 0, 0, 0, 0, 0, 1, 32'd84, 0, 0, 0, 0);
`else
    step("st_br_imm",  1, 1, 32'd64, 0, 0, 1, 32'd64, 1, 0, 0, 1);
    step("after_imm",  0, 0, 0, 0, 0, 1, 32'd68, 0, 0, 0, 0);
`endif

    // wrap at the top of the address range, sequential and redirect
    step("jmp244",   0, 0, 0, 1, 32'd244, 1, 32'd244, 1, 0, 0, 1);
    step("to248",    0, 0, 0, 0, 0, 1, 32'd248, 0, 0, 0, 0);
    step("wrap_seq", 0, 0, 0, 0, 0, 1, 32'd0,   0, 1, 0, 0);
    step("post_wrap",0, 0, 0, 0, 0, 1, 32'd4,   0, 0, 0, 0);
    step("wrap_jmp", 0, 0, 0, 1, 32'd300, 1, 32'd0, 1, 1, 0, 1);

    // reset mid-stall with a redirect outstanding
    step("st6", 1, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0);
`ifdef PC_REDIRECT_BUFFER_EN
    step("st6_buf", 1, 0, 0, 1, 32'd200, 0, 32'd0, 0, 0, 0, 0);
`else
    step("st6_imm", 1, 0, 0, 1, 32'd200, 1, 32'd200, 1, 0, 0, 1);
`endif
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    exp_align = 1'b0;
    exp_cnt   = 16'd0;
    pc_model  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("hold2",    0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0);
    step("restart",  0, 0, 0, 0, 0, 1, 32'd4, 0, 0, 0, 0);
    step("st7",      1, 0, 0, 0, 0, 0, 32'd4, 0, 0, 0, 0);
    step("rel7",     0, 0, 0, 0, 0, 0, 32'd4, 0, 0, 0, 0);
    step("resume7",  0, 0, 0, 0, 0, 1, 32'd8, 0, 0, 0, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
